// File: rtl/regfile_pkg.sv
// Shared constants, types and the stack-pointer operation decode for regfile_stack.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_NREGS  = 32;
  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_NREGS);

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    SP_NOP,
    SP_LOAD,
    SP_PUSH,
    SP_POP
  } sp_op_e;

  // Load beats everything; simultaneous push and pop cancel out.
  function automatic sp_op_e sp_decode(input logic we, input logic push, input logic pop);
    if (we)
      return SP_LOAD;
    else if (push && pop)
      return SP_NOP;
    else if (push)
      return SP_PUSH;
    else if (pop)
      return SP_POP;
    else
      return SP_NOP;
  endfunction

endpackage

// File: rtl/regfile_stack_if.sv
// Decode/execute-side bundle for regfile_stack: read ports, write port and SP controls.
interface regfile_stack_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              rd_a_en;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [DATA_W-1:0] rd_a_data;
  logic              rd_b_en;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [DATA_W-1:0] rd_b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              sp_we;
  logic [DATA_W-1:0] sp_in;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] sp_out;
  logic              sp_ovf;
  logic              sp_unf;

  modport master (
    output rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    output wr_en, wr_addr, wr_data,
    output sp_we, sp_in, push, pop,
    input  rd_a_data, rd_b_data, sp_out, sp_ovf, sp_unf
  );

  modport slave (
    input  rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    input  wr_en, wr_addr, wr_data,
    input  sp_we, sp_in, push, pop,
    output rd_a_data, rd_b_data, sp_out, sp_ovf, sp_unf
  );
endinterface

// File: rtl/regfile_sp_ctrl.sv
// Bounded, downward-growing stack pointer with sticky overflow/underflow flags.
module regfile_sp_ctrl
  import regfile_pkg::*;
#(
  parameter int                 DATA_W   = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0]  SP_INIT  = DATA_W'(16'hFFFF),
  parameter logic [DATA_W-1:0]  SP_LIMIT = DATA_W'(16'hFF00)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_sp_we,
  input  logic [DATA_W-1:0] i_sp_in,
  input  logic              i_push,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_sp,
  output logic              o_ovf,
  output logic              o_unf
);

  sp_op_e            w_op;
  logic [DATA_W-1:0] r_sp_reg;
  logic [DATA_W-1:0] w_sp_next;
  logic              r_ovf_reg;
  logic              w_ovf_next;
  logic              r_unf_reg;
  logic              w_unf_next;

  assign w_op = sp_decode(i_sp_we, i_push, i_pop);

  always_comb begin
    w_sp_next  = r_sp_reg;
    w_ovf_next = r_ovf_reg;
    w_unf_next = r_unf_reg;
    case (w_op)
      SP_LOAD: begin
        w_sp_next  = i_sp_in;
        w_ovf_next = 1'b0;
        w_unf_next = 1'b0;
      end
      SP_PUSH: begin
        if (r_sp_reg == SP_LIMIT)
          w_ovf_next = 1'b1;
        else
          w_sp_next = r_sp_reg - DATA_W'(1);
      end
      SP_POP: begin
        if (r_sp_reg == SP_INIT)
          w_unf_next = 1'b1;
        else
          w_sp_next = r_sp_reg + DATA_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp_reg  <= SP_INIT;
      r_ovf_reg <= 1'b0;
      r_unf_reg <= 1'b0;
    end else begin
      r_sp_reg  <= w_sp_next;
      r_ovf_reg <= w_ovf_next;
      r_unf_reg <= w_unf_next;
    end
  end

  assign o_sp  = r_sp_reg;
  assign o_ovf = r_ovf_reg;
  assign o_unf = r_unf_reg;

endmodule

// File: rtl/regfile_stack.sv
// Register file with two registered read ports, write-through forwarding,
// hardwired-zero r0 and an integrated stack-pointer unit.
module regfile_stack
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = DEFAULT_DATA_W,
  parameter int                NREGS    = DEFAULT_NREGS,
  parameter int                ADDR_W   = $clog2(NREGS),
  parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(16'hFFFF),
  parameter logic [DATA_W-1:0] SP_LIMIT = DATA_W'(16'hFF00)
) (
  input  logic            clk,
  input  logic            reset,
  regfile_stack_if.slave  bus
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [DATA_W-1:0] w_rd_a_val;
  logic [DATA_W-1:0] w_rd_b_val;
  logic [DATA_W-1:0] r_rd_a_data;
  logic [DATA_W-1:0] r_rd_b_data;
  logic              w_wr_live;

  assign w_wr_live = bus.wr_en && (bus.wr_addr != '0);

  // Every entry must clear on reset, so storage is a flop array rather than RAM.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset || gi == 0)
          r_mem[gi] <= '0;
        else if (w_wr_live && bus.wr_addr == ADDR_W'(gi))
          r_mem[gi] <= bus.wr_data;
      end
    end
  endgenerate

  // A same-cycle write to the address being read wins over the stored value.
  always_comb begin
    w_rd_a_val = r_mem[bus.rd_a_addr];
    if (bus.rd_a_addr == '0)
      w_rd_a_val = '0;
    else if (w_wr_live && bus.wr_addr == bus.rd_a_addr)
      w_rd_a_val = bus.wr_data;
  end

  always_comb begin
    w_rd_b_val = r_mem[bus.rd_b_addr];
    if (bus.rd_b_addr == '0)
      w_rd_b_val = '0;
    else if (w_wr_live && bus.wr_addr == bus.rd_b_addr)
      w_rd_b_val = bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_a_data <= '0;
      r_rd_b_data <= '0;
    end else begin
      if (bus.rd_a_en)
        r_rd_a_data <= w_rd_a_val;
      if (bus.rd_b_en)
        r_rd_b_data <= w_rd_b_val;
    end
  end

  assign bus.rd_a_data = r_rd_a_data;
  assign bus.rd_b_data = r_rd_b_data;

  regfile_sp_ctrl #(
    .DATA_W   (DATA_W),
    .SP_INIT  (SP_INIT),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp_ctrl (
    .clk     (clk),
    .reset   (reset),
    .i_sp_we (bus.sp_we),
    .i_sp_in (bus.sp_in),
    .i_push  (bus.push),
    .i_pop   (bus.pop),
    .o_sp    (bus.sp_out),
    .o_ovf   (bus.sp_ovf),
    .o_unf   (bus.sp_unf)
  );

endmodule

// File: tb/tb_regfile_stack.sv
// Directed bench for regfile_stack: register file, forwarding and stack pointer.
module tb_regfile_stack;

  localparam int DATA_W = 16;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_stack_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_stack #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .ADDR_W   (ADDR_W),
    .SP_INIT  (16'hFFFF),
    .SP_LIMIT (16'hFF00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_a_en = 0; bus.rd_a_addr = '0;
    bus.rd_b_en = 0; bus.rd_b_addr = '0;
    bus.wr_en = 0;   bus.wr_addr = '0; bus.wr_data = '0;
    bus.sp_we = 0;   bus.sp_in = '0;   bus.push = 0; bus.pop = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 5;
    if (bus.rd_a_data !== 16'h0) begin n_bad++; $display("FAIL reset_rd_a got %h want 0000", bus.rd_a_data); end
    if (bus.rd_b_data !== 16'h0) begin n_bad++; $display("FAIL reset_rd_b got %h want 0000", bus.rd_b_data); end
    if (bus.sp_out !== 16'hFFFF) begin n_bad++; $display("FAIL reset_sp got %h want ffff", bus.sp_out); end
    if (bus.sp_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", bus.sp_ovf); end
    if (bus.sp_unf !== 1'b0) begin n_bad++; $display("FAIL reset_unf got %b want 0", bus.sp_unf); end
    $display("reset: sp=%h a=%h b=%h", bus.sp_out, bus.rd_a_data, bus.rd_b_data);
  endtask

  task automatic test_write_read();
    bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 16'h1234;
    tick();
    bus.wr_en = 0;
    bus.rd_a_en = 1; bus.rd_a_addr = 5;
    bus.rd_b_en = 1; bus.rd_b_addr = 0;
    tick();
    n_cmp += 2;
    if (bus.rd_a_data !== 16'h1234) begin n_bad++; $display("FAIL rd_r5 got %h want 1234", bus.rd_a_data); end
    if (bus.rd_b_data !== 16'h0) begin n_bad++; $display("FAIL rd_r0 got %h want 0000", bus.rd_b_data); end
    $display("write r5 / read A=r5 B=r0: a=%h b=%h", bus.rd_a_data, bus.rd_b_data);
    idle();
    bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 16'hFFFF;
    tick();
    bus.wr_en = 0;
    bus.rd_a_en = 1; bus.rd_a_addr = 0;
    tick();
    n_cmp++;
    if (bus.rd_a_data !== 16'h0) begin n_bad++; $display("FAIL wr_r0_dropped got %h want 0000", bus.rd_a_data); end
    $display("write r0 / read r0: a=%h", bus.rd_a_data);
    idle();
  endtask

  task automatic test_forward();
    bus.wr_en = 1; bus.wr_addr = 7; bus.wr_data = 16'hBEEF;
    bus.rd_a_en = 1; bus.rd_a_addr = 7;
    tick();
    n_cmp++;
    if (bus.rd_a_data !== 16'hBEEF) begin n_bad++; $display("FAIL fwd_r7 got %h want beef", bus.rd_a_data); end
    $display("forward r7: a=%h", bus.rd_a_data);
    bus.wr_data = 16'h1111; bus.rd_a_en = 0;
    tick();
    n_cmp++;
    if (bus.rd_a_data !== 16'hBEEF) begin n_bad++; $display("FAIL hold_a got %h want beef", bus.rd_a_data); end
    $display("rd_a_en=0 hold: a=%h", bus.rd_a_data);
    idle();
    bus.rd_a_en = 1; bus.rd_a_addr = 5;
    bus.rd_b_en = 1; bus.rd_b_addr = 5;
    tick();
    n_cmp += 2;
    if (bus.rd_a_data !== 16'h1234) begin n_bad++; $display("FAIL dual_a got %h want 1234", bus.rd_a_data); end
    if (bus.rd_b_data !== 16'h1234) begin n_bad++; $display("FAIL dual_b got %h want 1234", bus.rd_b_data); end
    $display("dual read r5: a=%h b=%h", bus.rd_a_data, bus.rd_b_data);
    idle();
    bus.rd_b_en = 1; bus.rd_b_addr = 7;
    tick();
    n_cmp++;
    if (bus.rd_b_data !== 16'h1111) begin n_bad++; $display("FAIL later_r7 got %h want 1111", bus.rd_b_data); end
    $display("later read r7: b=%h", bus.rd_b_data);
    idle();
  endtask

  task automatic test_push_overflow();
    do_reset();
    bus.push = 1;
    tick();
    n_cmp++;
    if (bus.sp_out !== 16'hFFFE) begin n_bad++; $display("FAIL push1 got %h want fffe", bus.sp_out); end
    $display("push 1: sp=%h", bus.sp_out);
    for (int i = 1; i < 255; i++) tick();
    n_cmp += 2;
    if (bus.sp_out !== 16'hFF00) begin n_bad++; $display("FAIL push255 got %h want ff00", bus.sp_out); end
    if (bus.sp_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early got %b want 0", bus.sp_ovf); end
    $display("push 255: sp=%h ovf=%b", bus.sp_out, bus.sp_ovf);
    tick();
    n_cmp += 2;
    if (bus.sp_out !== 16'hFF00) begin n_bad++; $display("FAIL push_at_limit got %h want ff00", bus.sp_out); end
    if (bus.sp_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", bus.sp_ovf); end
    $display("push at limit: sp=%h ovf=%b", bus.sp_out, bus.sp_ovf);
    bus.push = 0; bus.pop = 1;
    tick();
    n_cmp += 2;
    if (bus.sp_out !== 16'hFF01) begin n_bad++; $display("FAIL pop_after_ovf got %h want ff01", bus.sp_out); end
    if (bus.sp_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", bus.sp_ovf); end
    $display("pop after ovf: sp=%h ovf=%b", bus.sp_out, bus.sp_ovf);
    idle();
  endtask

  task automatic test_underflow_load();
    do_reset();
    bus.pop = 1;
    tick();
    n_cmp += 2;
    if (bus.sp_unf !== 1'b1) begin n_bad++; $display("FAIL unf_set got %b want 1", bus.sp_unf); end
    if (bus.sp_out !== 16'hFFFF) begin n_bad++; $display("FAIL pop_at_init got %h want ffff", bus.sp_out); end
    $display("pop at init: sp=%h unf=%b", bus.sp_out, bus.sp_unf);
    bus.pop = 0; bus.sp_we = 1; bus.sp_in = 16'hFF80;
    tick();
    n_cmp += 3;
    if (bus.sp_out !== 16'hFF80) begin n_bad++; $display("FAIL load got %h want ff80", bus.sp_out); end
    if (bus.sp_unf !== 1'b0) begin n_bad++; $display("FAIL load_clr_unf got %b want 0", bus.sp_unf); end
    if (bus.sp_ovf !== 1'b0) begin n_bad++; $display("FAIL load_clr_ovf got %b want 0", bus.sp_ovf); end
    $display("sp_we ff80: sp=%h ovf=%b unf=%b", bus.sp_out, bus.sp_ovf, bus.sp_unf);
    bus.sp_we = 0; bus.push = 1; bus.pop = 1;
    tick();
    n_cmp++;
    if (bus.sp_out !== 16'hFF80) begin n_bad++; $display("FAIL push_pop got %h want ff80", bus.sp_out); end
    $display("push&&pop: sp=%h", bus.sp_out);
    bus.push = 0;
    tick();
    n_cmp++;
    if (bus.sp_out !== 16'hFF81) begin n_bad++; $display("FAIL pop_mid got %h want ff81", bus.sp_out); end
    $display("pop: sp=%h", bus.sp_out);
    idle();
  endtask

  task automatic test_load_priority_and_reset();
    bus.sp_we = 1; bus.sp_in = 16'hFFF0; bus.push = 1;
    tick();
    n_cmp++;
    if (bus.sp_out !== 16'hFFF0) begin n_bad++; $display("FAIL load_beats_push got %h want fff0", bus.sp_out); end
    $display("sp_we+push: sp=%h", bus.sp_out);
    bus.sp_we = 0;
    bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 16'hA5A5;
    tick();
    tick();
    n_cmp++;
    if (bus.sp_out !== 16'hFFEE) begin n_bad++; $display("FAIL burst got %h want ffee", bus.sp_out); end
    $display("push burst: sp=%h", bus.sp_out);
    reset = 1;
    tick();
    reset = 0;
    idle();
    n_cmp++;
    if (bus.sp_out !== 16'hFFFF) begin n_bad++; $display("FAIL mid_reset_sp got %h want ffff", bus.sp_out); end
    $display("reset mid-burst: sp=%h", bus.sp_out);
    for (int a = 0; a < NREGS; a++) begin
      bus.rd_a_en = 1; bus.rd_a_addr = ADDR_W'(a);
      bus.rd_b_en = 1; bus.rd_b_addr = ADDR_W'(NREGS - 1 - a);
      tick();
      n_cmp += 2;
      if (bus.rd_a_data !== 16'h0) begin n_bad++; $display("FAIL clr_a r%0d got %h want 0000", a, bus.rd_a_data); end
      if (bus.rd_b_data !== 16'h0) begin n_bad++; $display("FAIL clr_b r%0d got %h want 0000", NREGS - 1 - a, bus.rd_b_data); end
      $display("post-reset read r%0d/r%0d: a=%h b=%h", a, NREGS - 1 - a, bus.rd_a_data, bus.rd_b_data);
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_write_read();
    test_forward();
    test_push_overflow();
    test_underflow_load();
    test_load_priority_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
